// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for a single-port data memory with lock bursts and read-valid return
//   clk, rst (async, active-high)
//   req/we/lock/addr/wdata 0,1 : requester inputs, held until gnt
//   gnt0/gnt1     : combinational grant
//   rvalid0/1     : registered, read data valid the cycle after a read grant
//   rdata0/1      : ram_q pass-through
//   ram_data/ram_addr/ram_we/ram_mr/ram_q : memory side
//   DMEM_ARB_RR_EN : round-robin tie break when defined, fixed port-0 priority otherwise
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LOCK_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic                  ram_mr,
  input  logic [DATA_WIDTH-1:0] ram_q
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, state_nx;
  logic last, last_nx, frel, frel_nx, pick1, lk;
  logic [CW-1:0] lcnt, lcnt_nx, nc;
  // frel marks the cycle right after a forced release from OWN0; fixed priority yields that tie to port 1
`ifdef DMEM_ARB_RR_EN
  assign pick1 = ~last;
`else
  assign pick1 = frel;
`endif
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    state_nx = state;
    lcnt_nx = lcnt;
    last_nx = last;
    frel_nx = 1'b0;
    nc = '0;
    case (state)
      IDLE: begin
        gnt0 = req0 & ~(req1 & pick1) & ~rst;
        gnt1 = req1 & ~gnt0 & ~rst;
      end
      OWN0: gnt0 = req0 & ~rst;
      OWN1: gnt1 = req1 & ~rst;
      default: ;
    endcase
    lk = gnt0 ? lock0 : lock1;
    if (gnt0 | gnt1) begin
      last_nx = gnt1;
      nc = (state == IDLE) ? CW'(1) : lcnt + CW'(1);
      if (!lk) begin
        state_nx = IDLE;
        lcnt_nx = '0;
      end else if (nc >= LMAX) begin
        state_nx = IDLE;
        lcnt_nx = '0;
        frel_nx = gnt0;
      end else begin
        state_nx = gnt1 ? OWN1 : OWN0;
        lcnt_nx = nc;
      end
    end else if (state != IDLE) begin
      state_nx = IDLE;
      lcnt_nx = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
      lcnt <= '0;
      frel <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      state <= state_nx;
      last <= last_nx;
      lcnt <= lcnt_nx;
      frel <= frel_nx;
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
    end
  end
  assign ram_addr = gnt1 ? addr1 : addr0;
  assign ram_data = gnt1 ? wdata1 : wdata0;
  assign ram_we = (gnt0 & we0) | (gnt1 & we1);
  assign ram_mr = (gnt0 & ~we0) | (gnt1 & ~we1);
  assign rdata0 = ram_q;
  assign rdata1 = ram_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural single-port memory
module tb_dmem_arbiter;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk, rst;
  logic req0, req1, we0, we1, lock0, lock1;
  logic [4:0] addr0, addr1, ram_addr;
  logic [31:0] wdata0, wdata1, rdata0, rdata1, ram_data, ram_q;
  logic gnt0, gnt1, rvalid0, rvalid1, ram_we, ram_mr;
  logic [31:0] mem [32];
  logic [4:0] ra;
  typedef struct {bit port; logic [31:0] data; int due;} item_t;
  item_t q[$];
  int cyc = 0, asserts = 0, fails = 0;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_mr(ram_mr),
    .ram_q(ram_q)
  );

  initial begin
    clk = 0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    ra = '0;
  end
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    if (ram_mr) ra <= ram_addr;
  end
  assign ram_q = mem[ra];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      item_t e;
      e = q.pop_front();
      chk("rvalid0", {31'd0, rvalid0}, {31'd0, ~e.port});
      chk("rvalid1", {31'd0, rvalid1}, {31'd0, e.port});
      chk("rdata", e.port ? rdata1 : rdata0, e.data);
    end else
      chk("no_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
  end

  task automatic step(input string nm,
                      input logic r0, l0, w0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic r1, l1, w1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic e0, e1, input logic [31:0] ed);
    item_t it;
    req0 = r0; lock0 = l0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; lock1 = l1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(negedge clk);
    chk({nm, ".gnt"}, {30'd0, gnt0, gnt1}, {30'd0, e0, e1});
    chk({nm, ".ram_we"}, {31'd0, ram_we}, {31'd0, (e0 & w0) | (e1 & w1)});
    chk({nm, ".ram_mr"}, {31'd0, ram_mr}, {31'd0, (e0 & ~w0) | (e1 & ~w1)});
    if ((e0 & ~w0) | (e1 & ~w1)) begin
      it.port = e1; it.data = ed; it.due = cyc + 1;
      q.push_back(it);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    req0 = 1; req1 = 1; we0 = 1; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    @(negedge clk);
    chk("rst.gnt", {30'd0, gnt0, gnt1}, 32'd0);
    chk("rst.ram", {30'd0, ram_we, ram_mr}, 32'd0);
    @(posedge clk);
    #1 rst = 0;
    // write then read back
    step("wr3", 1, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 0);
    step("rd3", 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
    step("p1rd3", 0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 0, 1, 32'hDEADBEEF);
    // port 0 locked write burst, port 1 stalled
    step("bw0", 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    step("bw1", 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 1, 0, 0);
    step("bw2", 1, 0, 1, 2, 3, 1, 0, 0, 0, 0, 1, 0, 0);
    step("br0", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
    step("br1", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 2);
    step("br2", 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 3);
    // continuous contention
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = RR ? (i % 2 == 0) : 1'b1;
      step("tie", 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, g, ~g, g ? 32'd1 : 32'd2);
    end
    // port 1 lock hits LOCK_MAX=4
    step("l1a", 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0, 1, 3);
    for (int i = 0; i < 3; i++) step("l1b", 1, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0, 1, 3);
    step("l1rel", 1, 0, 0, 0, 0, 1, 1, 0, 2, 0, 1, 0, 1);
    step("l1end", 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 1, 3);
    // port 0 lock hits LOCK_MAX, port 1 gets the next tie in both builds
    for (int i = 0; i < 4; i++) step("l0", 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1);
    step("l0rel", 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 2);
    step("l0after", 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1);
    // OWN1 with req1 dropped: idle cycle, then port 0
    step("o1", 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0, 1, 3);
    step("o1idle", 1, 0, 1, 5, 32'hA5A50005, 0, 0, 0, 0, 0, 0, 0, 0);
    step("o1wr", 1, 0, 1, 5, 32'hA5A50005, 0, 0, 0, 0, 0, 1, 0, 0);
    step("raw", 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0, 32'hA5A50005);
    // reset during a locked read grant
    req0 = 0; req1 = 1; lock1 = 1; we1 = 0; addr1 = 3;
    @(negedge clk);
    chk("rg.gnt", {30'd0, gnt0, gnt1}, 32'd1);
    #1 rst = 1;
    #1 chk("rg.gate", {29'd0, gnt1, ram_mr, ram_we}, 32'd0);
    @(posedge clk);
    #1 chk("rg.rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
    rst = 0;
    step("post", 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1);
    step("drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("queue_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port data memory (32 x 32-bit, write on clock edge, registered read address). It shares the memory between port 0 (CPU load/store stage) and port 1 (debug/loader), with at most one access per cycle. It supports round-robin or fixed-priority arbitration, lock-based burst ownership with a bounded hold time, and a one-cycle read-valid return path. It sits between the requesters and the data memory instance in the top level.

## Interface

- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 5, word address width
- LOCK_MAX, 8, maximum consecutive locked grants before forced release (>=1)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  request to keep ownership after this grant
- addr0 / addr1  in  ADDR_WIDTH  word address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- gnt0 / gnt1  out  1  combinational; access accepted this cycle
- rvalid0 / rvalid1  out  1  registered; read data valid this cycle
- rdata0 / rdata1  out  DATA_WIDTH  read data, meaningful only when rvalid
- ram_data  out  DATA_WIDTH  to memory data
- ram_addr  out  ADDR_WIDTH  to memory addr
- ram_we  out  1  to memory we
- ram_mr  out  1  to memory mr (granted read)
- ram_q  in  DATA_WIDTH  from memory q

## Operation

- State machine has three states: IDLE, OWN0, OWN1. It also keeps a last-granted pointer `last` and a lock counter `lcnt` (ceil(log2(LOCK_MAX+1)) bits).
- IDLE:
  - If only one req is high, that port is granted.
  - If both are high, the winner is chosen per Configuration.
  - A grant with lock high moves the state to OWNi, with lcnt=1.
- OWNi:
  - Only port i can be granted; the other port's gnt stays 0.
  - Grant with lock_i=1: lcnt increments. If lcnt reaches LOCK_MAX, the next state is IDLE and `last`=i, so the other port wins the next tie.
  - Grant with lock_i=0: next state is IDLE.
  - No req_i: next state is IDLE and the cycle is idle. The other port is not granted in this cycle.
- Granted access drives the memory ports:
  - ram_addr = addr, ram_we = we, ram_data = wdata, ram_mr = ~we.
  - With no grant: ram_we=0, ram_mr=0. ram_addr and ram_data are don't-care; they are driven from port 0.
- Every grant updates `last` to the granted port.
- A read grant to port i sets rvalid_i=1 in the following cycle. rdata0 = rdata1 = ram_q (pass-through).
- Write grants produce no rvalid.
- Requesters hold req/we/addr/wdata/lock stable until gnt. Changes before grant are legal and take effect immediately.

## Timing

- Grant latency is 0 cycles: gnt is combinational from req and state.
- Read latency: data is returned in cycle N+1 for a grant in cycle N.
- Back-to-back reads are allowed. Throughput is one access per cycle.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Reset values:
  - state=IDLE, last=1 (port 0 wins the first tie), lcnt=0.
  - rvalid0=rvalid1=0.
  - gnt0=gnt1=0, ram_we=0, ram_mr=0 while rst is high.
- Reset mid-burst abandons ownership and drops any pending rvalid. No partial write occurs after reset assertion.
- LOCK_MAX=1 degenerates to no burst: forced release after every locked grant.

## Configuration

- DMEM_ARB_RR_EN defined: in an IDLE tie, the port != `last` wins (round robin).
- DMEM_ARB_RR_EN undefined: in an IDLE tie, port 0 always wins. The exception is the cycle immediately after a forced lock release from OWN0, where port 1 wins once.
- Lock, timeout and rvalid behaviour are identical in both builds.

## Test plan

- Reset, then port 0 writes 0xDEADBEEF to addr 3 and reads it the next cycle. Required: gnt0 in both cycles, rvalid0=1 one cycle after the read grant, rdata0=0xDEADBEEF.
- Both ports request reads continuously with RR_EN. Required: grants alternate 0,1,0,1 starting with port 0, and each rvalid arrives one cycle after its grant. With RR_EN undefined, port 0 is granted every cycle.
- Port 1 locks while port 0 requests, LOCK_MAX=4. Required: four consecutive gnt1, then gnt0 in the next cycle even though lock1 is still high.
- Port 0 locked burst of three writes to addr 0..2 (values 1,2,3), last with lock0=0. Required: port 1 is stalled for three cycles, then granted in the 4th. Port 1 reads of addr 0..2 return 1,2,3.
- In OWN1, req1 drops while req0 is high. Required: an idle cycle (ram_we=ram_mr=0), then gnt0.
- Assert rst during a read grant. Required: rvalid stays 0 the next cycle, state returns to IDLE, and the first post-reset tie goes to port 0.
